// File: rtl/fp_special_seq_if.sv
// Request/response bundle for fp_special_seq.
//   start/op/op_a/op_b      : operation request (sampled in IDLE)
//   busy/done/res/flags     : sequencer status and result
//   unit_start/op/a/b       : launch of an ordinary operand pair to the FPU core
//   unit_done/unit_res      : core completion
// slave  = sequencer side, master = requester / arithmetic-unit side.
interface fp_special_seq_if #(parameter int DATA_W = 32);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] res;
  logic              invalid;
  logic              div_zero;
  logic              unit_start;
  logic [1:0]        unit_op;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              unit_done;
  logic [DATA_W-1:0] unit_res;

  modport slave (
    input  start, op, op_a, op_b, unit_done, unit_res,
    output busy, done, res, invalid, div_zero, unit_start, unit_op, unit_a, unit_b
  );
  modport master (
    output start, op, op_a, op_b, unit_done, unit_res,
    input  busy, done, res, invalid, div_zero, unit_start, unit_op, unit_a, unit_b
  );
endinterface

// File: rtl/fp_special_seq.sv
// Special-value front end for the FPU arithmetic cores.
// Classifies both operands through one shared classifier (A then B), resolves
// NaN / inf / zero / subnormal cases locally, and forwards only ordinary
// operand pairs to the core via unit_start / unit_done.
// Ports: clk, rst (async active-high), bus (fp_special_seq_if.slave).
module fp_special_seq #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  fp_special_seq_if.slave    bus
);
  localparam int FRAC_W = DATA_W - EXP_W - 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [DATA_W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLS_A, CLS_B, DECIDE, WAIT} state_t;
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
  } cls_t;

  function automatic cls_t classify(input logic [DATA_W-1:0] v);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    cls_t              c;
    e      = v[DATA_W-2 -: EXP_W];
    f      = v[FRAC_W-1:0];
    c.nan  = (&e) && (|f);
    c.inf  = (&e) && !(|f);
    c.zero = !(|e) && !(|f);
    c.sub  = !(|e) && (|f);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] inf_of(input logic s);
    return {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] zero_of(input logic s);
    return {s, {(DATA_W-1){1'b0}}};
  endfunction

  state_t            state, state_d;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  cls_t              cls_a, cls_b, cls_cur;
  logic [DATA_W-1:0] res_q;
  logic              inv_q, dz_q, done_q, ustart_q;

  logic              load_req, load_cls_a, load_cls_b, fin_special, fire_unit, fin_unit;
  logic              spec_hit, spec_inv, spec_dz;
  logic [DATA_W-1:0] spec_res;

  // Shared classifier: the state picks which operand it sees.
  assign cls_cur = classify((state == CLS_A) ? a_q : b_q);

  // Special-case resolution. Subnormals count as zeros (flush-to-zero).
  logic za, zb, ia, ib, sa, sb, sx;
  always_comb begin
    za = cls_a.zero | cls_a.sub;
    zb = cls_b.zero | cls_b.sub;
    ia = cls_a.inf;
    ib = cls_b.inf;
    sa = a_q[DATA_W-1];
    sb = b_q[DATA_W-1];
    sx = sa ^ sb;
    spec_hit = 1'b1;
    spec_res = QNAN;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (cls_a.nan || cls_b.nan) begin
      spec_res = QNAN;
    end else if (op_q == OP_ADD || op_q == OP_SUB) begin
      // sub was folded into add at request time (b sign already flipped)
      if (ia && ib && sx)  spec_inv = 1'b1;
      else if (ia)         spec_res = inf_of(sa);
      else if (ib)         spec_res = inf_of(sb);
      else if (za && zb)   spec_res = zero_of(sa & sb);
      else if (za)         spec_res = b_q;
      else if (zb)         spec_res = a_q;
      else                 spec_hit = 1'b0;
    end else if (op_q == OP_MUL) begin
      if ((ia && zb) || (za && ib)) spec_inv = 1'b1;
      else if (ia || ib)            spec_res = inf_of(sx);
      else if (za || zb)            spec_res = zero_of(sx);
      else                          spec_hit = 1'b0;
    end else begin
      if ((za && zb) || (ia && ib)) spec_inv = 1'b1;
      else if (zb && !ia) begin
        spec_res = inf_of(sx);
        spec_dz  = 1'b1;
      end
      else if (ia)                  spec_res = inf_of(sx);
      else if (za || ib)            spec_res = zero_of(sx);
      else                          spec_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    load_req    = 1'b0;
    load_cls_a  = 1'b0;
    load_cls_b  = 1'b0;
    fin_special = 1'b0;
    fire_unit   = 1'b0;
    fin_unit    = 1'b0;
    case (state)
      IDLE:   if (bus.start) begin
                load_req = 1'b1;
                state_d  = CLS_A;
              end
      CLS_A:  begin
                load_cls_a = 1'b1;
                state_d    = CLS_B;
              end
      CLS_B:  begin
                load_cls_b = 1'b1;
                state_d    = DECIDE;
              end
      DECIDE: if (spec_hit) begin
                fin_special = 1'b1;
                state_d     = IDLE;
              end else begin
                fire_unit = 1'b1;
                state_d   = WAIT;
              end
      // A unit_done coinciding with our own start pulse is stale, not ours.
      WAIT:   if (bus.unit_done && !ustart_q) begin
                fin_unit = 1'b1;
                state_d  = IDLE;
              end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cls_a    <= '0;
      cls_b    <= '0;
      res_q    <= '0;
      inv_q    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      ustart_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ustart_q <= 1'b0;
      if (load_req) begin
        op_q <= (bus.op == OP_SUB) ? OP_ADD : bus.op;
        a_q  <= bus.op_a;
        b_q  <= bus.op_b ^ {(bus.op == OP_SUB), {(DATA_W-1){1'b0}}};
      end
      if (load_cls_a) cls_a <= cls_cur;
      if (load_cls_b) cls_b <= cls_cur;
      if (fin_special) begin
        res_q  <= spec_res;
        inv_q  <= spec_inv;
        dz_q   <= spec_dz;
        done_q <= 1'b1;
      end
      if (fire_unit) ustart_q <= 1'b1;
      if (fin_unit) begin
        res_q  <= bus.unit_res;
        inv_q  <= 1'b0;
        dz_q   <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.res        = res_q;
  assign bus.invalid    = inv_q;
  assign bus.div_zero   = dz_q;
  assign bus.unit_start = ustart_q;
  assign bus.unit_op    = op_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
endmodule

// File: tb/tb_fp_special_seq.sv
module tb_fp_special_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_special_seq_if #(.DATA_W(32)) bif ();

  fp_special_seq #(.DATA_W(32), .EXP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        inv;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request whose answer comes from the special-case path.
  task automatic run_special(input int idx, input vec_t v);
    int   lat;
    logic seen_us;
    lat     = -1;
    seen_us = 1'b0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.op    = v.op;
    bif.op_a  = v.a;
    bif.op_b  = v.b;
    @(negedge clk);
    bif.start = 1'b0;
    check($sformatf("v%0d busy", idx), 32'(bif.busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (bif.unit_start) seen_us = 1'b1;
      if (bif.done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'd3);
    check($sformatf("v%0d res", idx), bif.res, v.res);
    check($sformatf("v%0d invalid", idx), 32'(bif.invalid), 32'(v.inv));
    check($sformatf("v%0d div_zero", idx), 32'(bif.div_zero), 32'(v.dz));
    check($sformatf("v%0d unit_start", idx), 32'(seen_us), 32'd0);
    check($sformatf("v%0d busy_at_done", idx), 32'(bif.busy), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), 32'(bif.done), 32'd0);
  endtask

  // Ordinary pair: core result returned three cycles after unit_start.
  task automatic run_unit(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_ub,
                          input logic [31:0] ures, input logic [31:0] hold_res);
    int lat;
    lat = -1;
    @(negedge clk);
    bif.start = 1'b1;
    bif.op    = op;
    bif.op_a  = a;
    bif.op_b  = b;
    @(negedge clk);
    bif.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bif.unit_start || bif.done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({nm, " unit_start_lat"}, 32'(lat), 32'd3);
    check({nm, " unit_start"}, 32'(bif.unit_start), 32'd1);
    check({nm, " unit_a"}, bif.unit_a, a);
    check({nm, " unit_b"}, bif.unit_b, exp_ub);
    check({nm, " unit_op"}, 32'(bif.unit_op), 32'd0);
    // Stale unit_done alongside unit_start, plus a start while busy: both ignored.
    bif.unit_done = 1'b1;
    bif.unit_res  = 32'hDEADBEEF;
    bif.start     = 1'b1;
    bif.op        = 2'd3;
    bif.op_a      = 32'h0;
    bif.op_b      = 32'h0;
    @(negedge clk);
    bif.unit_done = 1'b0;
    bif.start     = 1'b0;
    check({nm, " stale_done"}, 32'(bif.done), 32'd0);
    check({nm, " wait_busy"}, 32'(bif.busy), 32'd1);
    check({nm, " res_hold"}, bif.res, hold_res);
    @(negedge clk);
    @(negedge clk);
    check({nm, " wait_no_done"}, 32'(bif.done), 32'd0);
    bif.unit_done = 1'b1;
    bif.unit_res  = ures;
    @(negedge clk);
    bif.unit_done = 1'b0;
    check({nm, " done"}, 32'(bif.done), 32'd1);
    check({nm, " res"}, bif.res, ures);
    check({nm, " invalid"}, 32'(bif.invalid), 32'd0);
    check({nm, " div_zero"}, 32'(bif.div_zero), 32'd0);
    check({nm, " idle"}, 32'(bif.busy), 32'd0);
    @(negedge clk);
    check({nm, " done_pulse"}, 32'(bif.done), 32'd0);
    check({nm, " no_requeue"}, 32'(bif.busy), 32'd0);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    vecs[0]  = '{2'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0};
    vecs[1]  = '{2'd2, 32'hFF800000, 32'h00000001, 32'h7FC00000, 1'b1, 1'b0};
    vecs[2]  = '{2'd2, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0, 1'b1};
    vecs[4]  = '{2'd3, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0};
    vecs[5]  = '{2'd1, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[6]  = '{2'd1, 32'h40000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0};
    vecs[7]  = '{2'd0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0};
    vecs[10] = '{2'd3, 32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0};
    vecs[11] = '{2'd2, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0};
    vecs[12] = '{2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0};
    vecs[13] = '{2'd1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0};

    rst           = 1'b1;
    bif.start     = 1'b0;
    bif.op        = 2'd0;
    bif.op_a      = '0;
    bif.op_b      = '0;
    bif.unit_done = 1'b0;
    bif.unit_res  = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bif.busy), 32'd0);
    check("rst done", 32'(bif.done), 32'd0);
    check("rst res", bif.res, 32'd0);
    check("rst flags", {30'd0, bif.invalid, bif.div_zero}, 32'd0);
    check("rst unit_start", 32'(bif.unit_start), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_special(i, vecs[i]);

    run_unit("add_unit", 2'd0, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 32'h7FC00000);
    run_unit("sub_unit", 2'd1, 32'h3F800000, 32'h40000000, 32'hC0000000, 32'hBF800000, 32'h40400000);

    // Reset while the core is working: its late result must be dropped.
    @(negedge clk);
    bif.start = 1'b1;
    bif.op    = 2'd2;
    bif.op_a  = 32'h40000000;
    bif.op_b  = 32'h40400000;
    @(negedge clk);
    bif.start = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bif.unit_start) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("rstw unit_start_lat", 32'(lat), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw busy", 32'(bif.busy), 32'd0);
    check("rstw res", bif.res, 32'd0);
    check("rstw unit_a", bif.unit_a, 32'd0);
    check("rstw unit_b", bif.unit_b, 32'd0);
    rst = 1'b0;
    bif.unit_done = 1'b1;
    bif.unit_res  = 32'h12345678;
    @(negedge clk);
    bif.unit_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstw no_done", 32'(bif.done), 32'd0);
      check("rstw res_kept", bif.res, 32'd0);
      @(negedge clk);
    end
    run_special(99, vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/fp_special_seq.md
# fp_special_seq

Sequencer placed in front of the FPU arithmetic units: accepts one operation (add, sub, mul, div) with two operands, classifies both through a single shared special-value classifier (one operand per cycle), and resolves special cases (NaN, infinity, zero, subnormal) directly. Only ordinary operand pairs are forwarded to the arithmetic unit through a start/done handshake. The unit's result is returned on the same `done`/`res` interface, so the arithmetic cores never see special operands.

## Interface
- `DATA_W`, 32: operand and result width.
- `EXP_W`, 8: exponent width. Fraction width is `DATA_W-EXP_W-1`.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request. Sampled only in IDLE.
- `op`  in  2  operation: 0 add, 1 sub, 2 mul, 3 div.
- `op_a`, `op_b`  in  DATA_W  operands, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse marking `res` and flags valid.
- `res`  out  DATA_W  result. Holds its value until the next `done`.
- `invalid`  out  1  invalid-operation flag, valid with `done`.
- `div_zero`  out  1  divide-by-zero flag, valid with `done`.
- `unit_start`  out  1  one-cycle start pulse to the arithmetic unit.
- `unit_a`, `unit_b`  out  DATA_W  registered operands to the unit. `unit_b` has its sign already flipped for sub; `op` is passed to the unit with sub reported as add.
- `unit_done`  in  1  unit completion. Sampled only in WAIT.
- `unit_res`  in  DATA_W  unit result, sampled with `unit_done`.

## Operation
- States: IDLE, CLS_A, CLS_B, DECIDE, WAIT.
- IDLE: on `start`, register `op`, `op_a`, and `op_b`. For sub, register `op_b` with its sign bit inverted. Go to CLS_A.
- CLS_A: the classifier input mux selects A. Register the class {nan, inf, zero, sub}. Go to CLS_B.
- CLS_B: same for B. Go to DECIDE.
- DECIDE: apply the rules below.
  - Special hit: set `res`, `invalid`, `div_zero`, pulse `done`, go to IDLE.
  - Otherwise: pulse `unit_start`, go to WAIT.
- WAIT: on `unit_done`, set `res` = `unit_res`, clear both flags, pulse `done`, go to IDLE.
- Subnormals are flushed to zero with their sign kept. A flushed zero result is ±0, never the subnormal pattern.
- qNaN is the canonical value: sign 0, exponent all ones, fraction MSB 1, other bits 0.
- Rules are evaluated in priority order. sa/sb are the signs after the sub flip; sx = sa^sb.
  - Any NaN → qNaN, `invalid`=0.
  - Add:
    - inf + inf with opposite signs → qNaN, `invalid`=1.
    - Any inf → that inf.
    - Both zero → +0, except -0 when both signs are negative.
    - One zero → the other operand.
  - Mul:
    - inf × zero → qNaN, `invalid`=1.
    - inf or zero present → inf or zero of sign sx.
  - Div:
    - 0/0 or inf/inf → qNaN, `invalid`=1.
    - finite nonzero / 0 → inf of sign sx, `div_zero`=1.
    - inf/x → inf of sign sx.
    - 0/x or x/inf → 0 of sign sx.

## Timing
- Reset values: state IDLE; `busy`, `done`, `unit_start`, `invalid`, `div_zero` = 0; `res`, `unit_a`, `unit_b` = 0.
- `start` high at edge k:
  - `busy`=1 from k.
  - Special result: `done`=1 for exactly the cycle after edge k+3 (latency 4).
  - Normal path: `unit_start`=1 for the cycle after edge k+3. `done` rises the cycle after the edge that samples `unit_done`.
- `start` while busy: ignored, with no queueing.
- `unit_done` outside WAIT: ignored.
- `unit_done` in the same cycle as the `unit_start` pulse: not accepted; sampling starts in WAIT.
- WAIT has no timeout.
- Back-to-back: `start` can be accepted in the cycle `done` is high, because the state is already IDLE.
- `rst` mid-operation: immediate return to IDLE with reset values. An in-flight unit result is discarded.

## Test plan
- add 0x7F800000 + 0xFF800000 → `res`=0x7FC00000, `invalid`=1, `done` exactly 4 cycles after `start`, no `unit_start`.
- mul 0xFF800000 × 0x00000001 (subnormal) → 0x7FC00000, `invalid`=1. mul 0xFF800000 × 0x3F800000 → 0xFF800000.
- div 0x3F800000 / 0x80000000 → 0xFF800000, `div_zero`=1. div 0x00000000 / 0x00000000 → 0x7FC00000, `invalid`=1.
- sub 0x80000000 - 0x00000000 → 0x80000000. sub 0x40000000 - 0x00000000 → 0x40000000.
- add 0x3F800000 + 0x40000000 → `unit_start` pulse at cycle 4. Model returns `unit_done` with 0x40400000 three cycles later → `res`=0x40400000 next cycle. An extra `start` during WAIT is ignored.
- Assert `rst` in WAIT, then pulse `unit_done` → all outputs at reset values, no `done`. A new request afterwards completes normally.
